md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the execute stage, directly downstream of the register-file/decode stage.
- Consumes read_data_1 (rs) and read_data_2 (rt) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers, which the ALU path reads for MFHI/MFLO.
- Multiply and divide are iterative, one result bit per cycle; md_busy stalls instruction fetch while an operation runs.

Parameters:
- WIDTH, 32, operand width. HI and LO are WIDTH bits each; the iteration count equals WIDTH. Only 32 is verified.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- md_start  in  1  request the operation in md_op this cycle.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved, no effect.
- read_data_1  in  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- read_data_2  in  WIDTH  rt operand (divisor / multiplier).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- md_busy  out  1  high while a multiply or divide is in progress.
- md_done  out  1  one-cycle pulse: new HI/LO from mul/div is visible.

Behaviour:
- Clock and reset are fixed: one clock, clock; reset_n is asynchronous, active-low.
- Reset (reset_n=0, at any time, including mid-operation):
  - hi=0, lo=0, md_busy=0, md_done=0, FSM to IDLE.
  - Any partial result is discarded.
- FSM states: IDLE, ITER, FIX.
- Accept rule: a request is accepted only when md_start=1 and the state is IDLE. md_start while busy is ignored; it is not queued.
- MTHI / MTLO (accepted in IDLE):
  - hi (or lo) takes read_data_1 at the accepting edge.
  - The other register is unchanged.
  - md_busy and md_done stay 0 and the FSM stays IDLE.
- MULT / MULTU / DIV / DIVU accepted at edge E0:
  - Operands are latched at E0; later operand changes have no effect.
  - Signed ops convert operands to magnitudes and record the result signs.
  - State goes to ITER with counter=0.
- ITER: one step per cycle, edges E1..E32; counter reaches WIDTH-1 at E32, then state goes to FIX.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring division with a WIDTH+1-bit partial remainder.
- FIX (edge E33):
  - Apply sign correction, write hi/lo, set md_done=1 for exactly one cycle, return to IDLE.
  - hi/lo keep their old values from E0 until E33.
- md_busy is 1 from after E0 through the FIX cycle, i.e. 33 cycles. md_busy=0 in the cycle md_done=1, so a new request may be accepted that same cycle.
- Result rules:
  - MULT/MULTU: {hi,lo} = 64-bit product. MULT negates the magnitude product when the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
  - Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=read_data_1 as latched. Latency is still 33 cycles.
- Reserved md_op with md_start=1: no state change.

Decomposition:
- Shared package md_pkg: md_op encodings (MD_MULT..MD_MTLO), FSM state encodings, WIDTH default.
- One sub-module, md_iter_core: magnitude-only shift-add / restoring-divide datapath, one step per enable.
  - Inputs: load, step, is_div, operand magnitudes.
  - Outputs: 2*WIDTH raw result.
- Sign handling, FSM, counter and HI/LO stay in md_unit.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> immediately hi=0, lo=0, md_busy=0, md_done=0. Release -> FSM in IDLE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001 after exactly 33 busy cycles.
  - md_done high one cycle; operand changes during busy have no effect.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV checks:
  - DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007 after 33 cycles.
- Control checks:
  - MTHI 0x12345678 in IDLE -> hi updates next edge, lo unchanged, md_busy stays 0.
  - md_start(MTLO) during a running DIV -> ignored.
  - reset_n pulled low at cycle 10 of a MULT -> busy drops, hi=lo=0, next MULT runs a full 33 cycles correctly.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states and
// the per-operation flags captured when an operation is accepted.
package md_pkg;
    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef struct packed {
        logic is_div;
        logic neg_res;   // product / quotient must be negated
        logic neg_rem;   // remainder follows the dividend sign
        logic div0;
    } md_flags_t;
endpackage

// File: rtl/md_iter_core.sv
// Magnitude-only iterative datapath: shift-add multiply or restoring divide,
// one result bit per step. Divide result is packed as {remainder, quotient}.
module md_iter_core
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   result
);
    logic               div_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;

    // Low half of acc_q holds the multiplier (mul) or the dividend shifting into quotient (div)
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
        end else if (load) begin
            div_q  <= is_div;
            opnd_q <= is_div ? b_mag : a_mag;
            acc_q  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            rem_q  <= '0;
        end else if (step) begin
            if (div_q) begin
                acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                rem_q            <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            end else begin
                acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    assign result = div_q ? {rem_q, acc_q[WIDTH-1:0]} : acc_q;
endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding HI/LO. Iterative ops take 33 busy
// cycles (WIDTH steps plus a sign-fix cycle); MTHI/MTLO write in one edge.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] read_data_2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
    output logic             md_done
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    md_flags_t          flags_q, flags_d;

    logic               signed_op, a_neg, b_neg, load;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] raw, prod_fix;

    assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign a_neg     = signed_op & read_data_1[WIDTH-1];
    assign b_neg     = signed_op & read_data_2[WIDTH-1];
    assign a_mag     = a_neg ? -read_data_1 : read_data_1;
    assign b_mag     = b_neg ? -read_data_2 : read_data_2;
    // md_op 0..3 are the iterative ops; bit 1 separates divide from multiply
    assign load      = md_start && (state_q == ST_IDLE) && !md_op[2];

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .step    (state_q == ST_ITER),
        .is_div  (md_op[1]),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .result  (raw)
    );

    assign prod_fix = flags_q.neg_res ? -raw : raw;
    assign quo      = raw[WIDTH-1:0];
    assign rem      = raw[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    if (md_op == MD_MTHI) begin
                        hi_d = read_data_1;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = read_data_1;
                    end else if (!md_op[2]) begin
                        state_d = ST_ITER;
                        cnt_d   = '0;
                        flags_d = '{is_div:  md_op[1],
                                    neg_res: a_neg ^ b_neg,
                                    neg_rem: a_neg,
                                    div0:    (read_data_2 == '0)};
                    end
                end
            end
            ST_ITER: begin
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (flags_q.is_div) begin
                    // Remainder magnitude equals |rs| on divide-by-zero, so sign fix restores rs
                    lo_d = flags_q.div0 ? '1 : (flags_q.neg_res ? -quo : quo);
                    hi_d = flags_q.neg_rem ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            flags_q <= flags_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign md_busy = (state_q != ST_IDLE);
    assign md_done = done_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected {hi,lo} pushed at
// issue and popped on md_done, plus directed control/reset scenarios.
module tb_md_unit;
    import md_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        md_start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] read_data_1 = '0;
    logic [31:0] read_data_2 = '0;
    logic [31:0] hi, lo;
    logic        md_busy, md_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    md_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .md_start    (md_start),
        .md_op       (md_op),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .hi          (hi),
        .lo          (lo),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        p = '0;
        case (op)
            MD_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
            end
            MD_MULTU: p = {32'd0, a} * {32'd0, b};
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == MD_DIV) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Drives one request for one cycle; mul/div results go onto the scoreboard.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1;
        md_op = op;
        read_data_1 = a;
        read_data_2 = b;
        if (op <= MD_DIVU) exp_q.push_back(model(op, a, b));
        @(posedge clock);
        #1;
        md_start = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit seen, output bit moved);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        bc = 0;
        seen = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (md_done) begin
                seen = 1'b1;
                break;
            end
            if (md_busy) bc++;
            if (hi !== h0 || lo !== l0) moved = 1'b1;
        end
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start_op(MD_MTHI, 32'hAAAA_5555, 32'd0);
        start_op(MD_MTLO, 32'h5555_AAAA, 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({hi, lo, md_busy, md_done} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_async got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, md_busy, md_done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({md_busy, md_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release got busy=%b done=%b want 0 0", md_busy, md_done);
        end
    endtask

    task automatic test_multu;
        int bc;
        bit seen, moved;
        logic [63:0] e;
        @(negedge clock);
        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_data_1 = 32'h0000_1234;
        read_data_2 = 32'h0000_0005;
        wait_done(bc, seen, moved);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || bc != 33) begin
            n_bad++;
            $display("FAIL multu_latency got done=%b busy_cycles=%0d want 1 33", seen, bc);
        end
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_bad++;
            $display("FAIL multu_result got %h want %h", {hi, lo}, e);
        end
        n_cmp++;
        if (moved) begin
            n_bad++;
            $display("FAIL multu_hold got hi/lo changed while busy want unchanged");
        end
        n_cmp++;
        if (md_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL multu_busy_at_done got %b want 0", md_busy);
        end
        @(negedge clock);
        n_cmp++;
        if (md_done !== 1'b0) begin
            n_bad++;
            $display("FAIL multu_done_pulse got %b want 0", md_done);
        end
    endtask

    task automatic test_signed;
        int bc;
        bit seen, moved;
        logic [63:0] e;
        logic [2:0]  ops[4] = '{MD_MULT, MD_DIV, MD_DIV, MD_DIVU};
        logic [31:0] as[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
        logic [31:0] bs[4]  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            start_op(ops[k], as[k], bs[k]);
            wait_done(bc, seen, moved);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || bc != 33) begin
                n_bad++;
                $display("FAIL signed_latency[%0d] got done=%b busy_cycles=%0d want 1 33", k, seen, bc);
            end
            n_cmp++;
            if ({hi, lo} !== e) begin
                n_bad++;
                $display("FAIL signed_result[%0d] got %h want %h", k, {hi, lo}, e);
            end
        end
    endtask

    task automatic test_mthi;
        logic [31:0] l0;
        @(negedge clock);
        l0 = lo;
        start_op(MD_MTHI, 32'h1234_5678, 32'hDEAD_BEEF);
        n_cmp++;
        if (hi !== 32'h1234_5678 || lo !== l0) begin
            n_bad++;
            $display("FAIL mthi_write got hi=%h lo=%h want hi=12345678 lo=%h", hi, lo, l0);
        end
        @(negedge clock);
        n_cmp++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            n_bad++;
            $display("FAIL mthi_flags got busy=%b done=%b want 0 0", md_busy, md_done);
        end
    endtask

    task automatic test_ignore;
        int bc;
        bit seen, moved;
        logic [63:0] e;
        @(negedge clock);
        start_op(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clock);
        start_op(MD_MTLO, 32'hDEAD_0000, 32'd0);
        wait_done(bc, seen, moved);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || {hi, lo} !== e) begin
            n_bad++;
            $display("FAIL ignore_mtlo got done=%b %h want %h", seen, {hi, lo}, e);
        end
        @(negedge clock);
        n_cmp++;
        if (lo !== e[31:0]) begin
            n_bad++;
            $display("FAIL ignore_after got lo=%h want %h", lo, e[31:0]);
        end
    endtask

    task automatic test_reset_mid;
        int bc;
        bit seen, moved;
        logic [63:0] e;
        @(negedge clock);
        start_op(MD_MULT, 32'h1111_1111, 32'd3);
        repeat (9) @(negedge clock);
        n_cmp++;
        if (md_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_busy got %b want 1", md_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({hi, lo, md_busy, md_done} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_mid_clear got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, md_busy, md_done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start_op(MD_MULT, 32'hFFFF_FFFB, 32'd6);
        wait_done(bc, seen, moved);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || bc != 33 || {hi, lo} !== e) begin
            n_bad++;
            $display("FAIL reset_mid_rerun got done=%b cycles=%0d %h want 1 33 %h", seen, bc, {hi, lo}, e);
        end
    endtask

    task automatic test_back_to_back;
        int bc;
        bit seen, moved;
        logic [63:0] e;
        logic [2:0]  op;
        logic [31:0] a, b;
        @(negedge clock);
        start_op(MD_DIVU, 32'hFFFF_FFFF, 32'd10);
        wait_done(bc, seen, moved);
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || {hi, lo} !== e) begin
                n_bad++;
                $display("FAIL b2b_result[%0d] got done=%b %h want %h", k, seen, {hi, lo}, e);
            end
            // Issue during the done cycle: the unit must accept it immediately
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (k % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (k == 7) b = 32'd0;
            start_op(op, a, b);
            wait_done(bc, seen, moved);
            n_cmp++;
            if (bc != 33) begin
                n_bad++;
                $display("FAIL b2b_latency[%0d] got %0d want 33", k, bc);
            end
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || {hi, lo} !== e) begin
            n_bad++;
            $display("FAIL b2b_last got done=%b %h want %h", seen, {hi, lo}, e);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_mthi();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
